// File: rtl/axis_frame_fifo_pkg.sv
// Shared types and helpers for the parametrised AXI-Stream frame FIFO.
// Width helpers are functions because the widths depend on per-instance parameters.
package axis_frame_fifo_pkg;

   localparam int unsigned MAX_USER_WIDTH = 32;

   typedef logic [MAX_USER_WIDTH-1:0] user_word_t;

   typedef enum logic {
      WR_STORE = 1'b0,
      WR_DROP  = 1'b1
   } wr_state_t;

   // Pointer width: one extra wrap bit distinguishes full from empty.
   function automatic int unsigned ptr_width(input int unsigned addr_width);
      return addr_width + 1;
   endfunction

   // Packed RAM beat layout: {tlast, tuser, tdata}.
   function automatic int unsigned beat_width(input int unsigned data_width,
                                              input int unsigned user_width);
      return data_width + user_width + 1;
   endfunction

   function automatic logic is_bad_frame(input user_word_t user,
                                         input user_word_t value,
                                         input user_word_t mask);
      return (user & mask) == (value & mask);
   endfunction

endpackage

// File: rtl/axis_frame_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register doubles as the FIFO output register, so it is reset.
module axis_frame_fifo_ram #(
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned WIDTH      = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/axis_frame_fifo_param.sv
// Store-and-forward AXI-Stream frame FIFO; only committed frames reach the output.
// Optional frame_count output is enabled by defining AXIS_FRAME_FIFO_FRAME_CNT_EN.
module axis_frame_fifo_param
   import axis_frame_fifo_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH           = 2,
   parameter int unsigned           DATA_WIDTH           = 8,
   parameter int unsigned           USER_WIDTH           = 1,
   parameter bit                    DROP_WHEN_FULL       = 1'b1,
   parameter bit                    DROP_BAD_FRAME       = 1'b0,
   parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = USER_WIDTH'(1),
   parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = USER_WIDTH'(1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] input_axis_tdata,
   input  logic                  input_axis_tvalid,
   output logic                  input_axis_tready,
   input  logic                  input_axis_tlast,
   input  logic [USER_WIDTH-1:0] input_axis_tuser,
   output logic [DATA_WIDTH-1:0] output_axis_tdata,
   output logic                  output_axis_tvalid,
   input  logic                  output_axis_tready,
   output logic                  output_axis_tlast,
   output logic [USER_WIDTH-1:0] output_axis_tuser,
   output logic                  drop_frame,
   output logic                  overflow,
   output logic                  bad_frame,
   output logic                  good_frame,
   output logic [ADDR_WIDTH:0]   occupancy
`ifdef AXIS_FRAME_FIFO_FRAME_CNT_EN
   ,
   output logic [ADDR_WIDTH:0]   frame_count
`endif
);

   localparam int unsigned PW = ptr_width(ADDR_WIDTH);
   localparam int unsigned BW = beat_width(DATA_WIDTH, USER_WIDTH);

   typedef logic [PW-1:0] ptr_t;

   ptr_t      wr_ptr, wr_ptr_cur, rd_ptr;
   wr_state_t wr_state;
   logic      full_cur, empty, wr_accept, ram_wr_en, rd_load, last_is_bad;
   logic [BW-1:0] rd_beat;

   assign full_cur = (wr_ptr_cur[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr_cur[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
   assign empty    = (wr_ptr == rd_ptr);

   // Frames longer than the FIFO deadlock when DROP_WHEN_FULL is 0.
   assign input_axis_tready = rst_n && (DROP_WHEN_FULL ? 1'b1 : !full_cur);
   assign wr_accept         = input_axis_tvalid && input_axis_tready;
   assign ram_wr_en         = wr_accept && (wr_state == WR_STORE) &&
                              !(full_cur && DROP_WHEN_FULL);
   assign last_is_bad       = DROP_BAD_FRAME &&
                              is_bad_frame(user_word_t'(input_axis_tuser),
                                           user_word_t'(USER_BAD_FRAME_VALUE),
                                           user_word_t'(USER_BAD_FRAME_MASK));
   assign drop_frame        = (wr_state == WR_DROP);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         wr_ptr_cur <= '0;
         wr_state   <= WR_STORE;
         overflow   <= 1'b0;
         bad_frame  <= 1'b0;
         good_frame <= 1'b0;
      end else begin
         overflow   <= 1'b0;
         bad_frame  <= 1'b0;
         good_frame <= 1'b0;
         if (wr_accept) begin
            if (wr_state == WR_DROP) begin
               if (input_axis_tlast) begin
                  wr_state <= WR_STORE;
                  overflow <= 1'b1;
               end
            end else if (full_cur && DROP_WHEN_FULL) begin
               wr_ptr_cur <= wr_ptr;
               if (input_axis_tlast) begin
                  overflow <= 1'b1;
               end else begin
                  wr_state <= WR_DROP;
               end
            end else if (input_axis_tlast) begin
               if (last_is_bad) begin
                  wr_ptr_cur <= wr_ptr;
                  bad_frame  <= 1'b1;
               end else begin
                  wr_ptr     <= wr_ptr_cur + 1'b1;
                  wr_ptr_cur <= wr_ptr_cur + 1'b1;
                  good_frame <= 1'b1;
               end
            end else begin
               wr_ptr_cur <= wr_ptr_cur + 1'b1;
            end
         end
      end
   end

   assign rd_load = !empty && (!output_axis_tvalid || output_axis_tready);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr             <= '0;
         output_axis_tvalid <= 1'b0;
      end else if (rd_load) begin
         rd_ptr             <= rd_ptr + 1'b1;
         output_axis_tvalid <= 1'b1;
      end else if (output_axis_tready) begin
         output_axis_tvalid <= 1'b0;
      end
   end

   axis_frame_fifo_ram #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .WIDTH     (BW)
   ) u_ram (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (ram_wr_en),
      .wr_addr(wr_ptr_cur[ADDR_WIDTH-1:0]),
      .wr_data({input_axis_tlast, input_axis_tuser, input_axis_tdata}),
      .rd_en  (rd_load),
      .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
      .rd_data(rd_beat)
   );

   assign {output_axis_tlast, output_axis_tuser, output_axis_tdata} = rd_beat;
   assign occupancy = wr_ptr - rd_ptr;

`ifdef AXIS_FRAME_FIFO_FRAME_CNT_EN
   logic out_last_hs;
   assign out_last_hs = output_axis_tvalid && output_axis_tready && output_axis_tlast;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_count <= '0;
      end else begin
         case ({good_frame, out_last_hs})
            2'b10:   frame_count <= frame_count + 1'b1;
            2'b01:   frame_count <= frame_count - 1'b1;
            default: frame_count <= frame_count;
         endcase
      end
   end
`endif

endmodule
